// File: rtl/cpu_pkg.sv
// Shared CPU definitions: divider opcodes, divider FSM states and the ALU-to-divider dispatch mapping.
package cpu_pkg;

    localparam logic [1:0] DIV_OP_DIVS = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_MODS = 2'b10;
    localparam logic [1:0] DIV_OP_MODU = 2'b11;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_CALC = 2'b01,
        DIV_FIX  = 2'b10
    } div_state_e;

    // ALU-reserved opcodes handed to the divider: 1000 selects DIV*, 1001 selects MOD*
    localparam logic [3:0] ALU_OP_DIV = 4'b1000;
    localparam logic [3:0] ALU_OP_MOD = 4'b1001;

    function automatic logic is_div_dispatch(input logic [3:0] alu_op);
        return (alu_op[3:1] == 3'b100);
    endfunction

    function automatic logic [1:0] div_op_from_alu(input logic [3:0] alu_op, input logic is_unsigned);
        return {alu_op[0], is_unsigned};
    endfunction

endpackage

// File: rtl/alu_div_step.sv
// One radix-2 restoring division iteration: shift {rem,quo} left and trial-subtract the divisor.
module alu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] trial_s;

    // Keep the difference only when it did not borrow (MSB clear)
    always_comb begin
        shifted_s = {rem, quo[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, divisor};
        if (!trial_s[WIDTH]) begin
            rem_next = trial_s[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted_s[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/alu_divider.sv
// Multi-cycle divide/modulo unit with start/busy/done handshake.
// Optional macro ALU_DIVIDER_SIGNED_EN compiles in signed DIVS/MODS; otherwise all ops are unsigned.
module alu_divider
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       opcode,
    input  logic             start,
    output logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    div_state_e       state_r, next_state_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] rem_r, quo_r, div_r, a_raw_r, y_r;
    logic [WIDTH-1:0] abs_a_s, abs_b_s, step_rem_s, step_quo_s, result_s;
    logic             is_mod_r, busy_r, done_r, div_zero_s;

`ifdef ALU_DIVIDER_SIGNED_EN
    logic a_neg_s, b_neg_s, q_neg_r, r_neg_r;
    assign a_neg_s = ~opcode[0] & a[WIDTH-1];
    assign b_neg_s = ~opcode[0] & b[WIDTH-1];
    assign abs_a_s = a_neg_s ? ({WIDTH{1'b0}} - a) : a;
    assign abs_b_s = b_neg_s ? ({WIDTH{1'b0}} - b) : b;
`else
    logic op_unused_s;
    assign op_unused_s = opcode[0];
    assign abs_a_s     = a;
    assign abs_b_s     = b;
`endif

    assign div_zero_s = (div_r == {WIDTH{1'b0}});

    alu_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (div_r),
        .rem_next (step_rem_s),
        .quo_next (step_quo_s)
    );

    // Final result selection, including divide-by-zero and sign correction
    always_comb begin
        if (div_zero_s) begin
            result_s = is_mod_r ? a_raw_r : {WIDTH{1'b1}};
        end else if (is_mod_r) begin
`ifdef ALU_DIVIDER_SIGNED_EN
            result_s = r_neg_r ? ({WIDTH{1'b0}} - rem_r) : rem_r;
`else
            result_s = rem_r;
`endif
        end else begin
`ifdef ALU_DIVIDER_SIGNED_EN
            result_s = q_neg_r ? ({WIDTH{1'b0}} - quo_r) : quo_r;
`else
            result_s = quo_r;
`endif
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= DIV_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a zero divisor leaves CALC without iterating
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            DIV_IDLE: begin
                if (start) next_state_s = DIV_CALC;
                else       next_state_s = DIV_IDLE;
            end
            DIV_CALC: begin
                if (div_zero_s || (cnt_r == {CW{1'b0}})) next_state_s = DIV_FIX;
                else                                       next_state_s = DIV_CALC;
            end
            DIV_FIX:  next_state_s = DIV_IDLE;
            default:  next_state_s = DIV_IDLE;
        endcase
    end

    // Datapath and registered handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r    <= {CW{1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            quo_r    <= {WIDTH{1'b0}};
            div_r    <= {WIDTH{1'b0}};
            a_raw_r  <= {WIDTH{1'b0}};
            y_r      <= {WIDTH{1'b0}};
            is_mod_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
`ifdef ALU_DIVIDER_SIGNED_EN
            q_neg_r  <= 1'b0;
            r_neg_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                DIV_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_raw_r  <= a;
                        quo_r    <= abs_a_s;
                        div_r    <= abs_b_s;
                        rem_r    <= {WIDTH{1'b0}};
                        cnt_r    <= CW'(WIDTH - 1);
                        is_mod_r <= opcode[1];
                        busy_r   <= 1'b1;
`ifdef ALU_DIVIDER_SIGNED_EN
                        q_neg_r  <= a_neg_s ^ b_neg_s;
                        r_neg_r  <= a_neg_s;
`endif
                    end
                end
                DIV_CALC: begin
                    if (!div_zero_s) begin
                        rem_r <= step_rem_s;
                        quo_r <= step_quo_s;
                        if (cnt_r != {CW{1'b0}}) cnt_r <= cnt_r - CW'(1);
                    end
                end
                DIV_FIX: begin
                    y_r    <= result_s;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign y    = y_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule
